// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave-side bus, grants are
// held for a whole cyc, and a watchdog errors out strobes that no slave answers.
module wb_rr_arbiter #(
  parameter int N       = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*AW-1:0] m_adr_i,
  input  logic [N*DW-1:0] m_dat_i,
  input  logic [N-1:0]    m_we_i,
  input  logic [N*4-1:0]  m_sel_i,
  input  logic [N-1:0]    m_stb_i,
  input  logic [N-1:0]    m_cyc_i,
  output logic [DW-1:0]   m_dat_o,
  output logic [N-1:0]    m_ack_o,
  output logic [N-1:0]    m_err_o,
  output logic [N-1:0]    m_rty_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic            s_we_o,
  output logic [3:0]      s_sel_o,
  output logic            s_stb_o,
  output logic            s_cyc_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  output logic [N-1:0]    gnt_o
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [LW-1:0]   last;
  logic [CW-1:0]   wd_cnt;

  logic            busy;
  logic            cyc_g;
  logic            stb_g;
  logic            resp;
  logic            stalled;
  logic            wd_fire;
  logic [LW:0]     pick;

  // Scan last+1, last+2, ... mod N; returns {found, winner index}.
  function automatic logic [LW:0] rr_pick(input logic [N-1:0] req,
                                          input logic [LW-1:0] prev);
    logic [LW:0] res;
    res = '0;
    for (int i = N; i >= 1; i--) begin
      logic [LW-1:0] idx;
      idx = LW'((int'(prev) + i) % N);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign pick = rr_pick(m_cyc_i, last);
  assign busy = (state == BUSY);

  // Datapath: everything below is combinational from the registered grant.
  assign cyc_g   = busy & |(gnt_o & m_cyc_i);
  assign stb_g   = cyc_g & |(gnt_o & m_stb_i);
  assign resp    = s_ack_i | s_err_i | s_rty_i;
  assign stalled = stb_g & ~resp;
  assign wd_fire = (TIMEOUT != 0) && stalled && (int'(wd_cnt) == TIMEOUT - 1);

  assign s_cyc_o = cyc_g & ~wd_fire;
  assign s_stb_o = stb_g & ~wd_fire;
  assign m_ack_o = gnt_o & {N{s_ack_i & s_cyc_o}};
  assign m_rty_o = gnt_o & {N{s_rty_i & s_cyc_o}};
  assign m_err_o = gnt_o & {N{(s_err_i & s_cyc_o) | wd_fire}};
  assign m_dat_o = s_dat_i;

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_o[k]) begin
        s_adr_o = m_adr_i[k*AW +: AW];
        s_dat_o = m_dat_i[k*DW +: DW];
        s_we_o  = m_we_i[k];
        s_sel_o = m_sel_i[k*4 +: 4];
      end
    end
  end

  // Control: grant FSM, round-robin pointer and watchdog counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt_o  <= '0;
      last   <= LW'(N - 1);
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (pick[LW]) begin
            state <= BUSY;
            gnt_o <= {{(N-1){1'b0}}, 1'b1} << pick[LW-1:0];
            last  <= pick[LW-1:0];
          end
        end
        BUSY: begin
          if (!cyc_g) begin
            // Release; the mandatory IDLE cycle gives the next owner a fair scan.
            state  <= IDLE;
            gnt_o  <= '0;
            wd_cnt <= '0;
          end else if (stalled && !wd_fire) begin
            wd_cnt <= wd_cnt + CW'(1);
          end else begin
            wd_cnt <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          gnt_o  <= '0;
          wd_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic checked against a cycle-level ownership model.
module tb_wb_rr_arbiter;
  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NM*AW-1:0] adr;
  logic [NM*DW-1:0] wdat;
  logic [NM-1:0]    we, stb, cyc;
  logic [NM*4-1:0]  sel;
  logic [DW-1:0]    sdat;
  logic             sack, serr, srty;

  logic [DW-1:0] m_dat, n_m_dat;
  logic [NM-1:0] m_ack, m_err, m_rty, gnt, n_m_ack, n_m_err, n_m_rty, n_gnt;
  logic [AW-1:0] s_adr, n_s_adr;
  logic [DW-1:0] s_dat, n_s_dat;
  logic          s_we, s_stb, s_cyc, n_s_we, n_s_stb, n_s_cyc;
  logic [3:0]    s_sel, n_s_sel;

  wb_rr_arbiter #(.N(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m_adr_i(adr), .m_dat_i(wdat), .m_we_i(we), .m_sel_i(sel),
    .m_stb_i(stb), .m_cyc_i(cyc),
    .m_dat_o(m_dat), .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty),
    .s_adr_o(s_adr), .s_dat_o(s_dat), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_stb_o(s_stb), .s_cyc_o(s_cyc),
    .s_dat_i(sdat), .s_ack_i(sack), .s_err_i(serr), .s_rty_i(srty),
    .gnt_o(gnt)
  );

  wb_rr_arbiter #(.N(NM), .AW(AW), .DW(DW), .TIMEOUT(0)) dut_nowd (
    .clk(clk), .reset(reset),
    .m_adr_i(adr), .m_dat_i(wdat), .m_we_i(we), .m_sel_i(sel),
    .m_stb_i(stb), .m_cyc_i(cyc),
    .m_dat_o(n_m_dat), .m_ack_o(n_m_ack), .m_err_o(n_m_err), .m_rty_o(n_m_rty),
    .s_adr_o(n_s_adr), .s_dat_o(n_s_dat), .s_we_o(n_s_we), .s_sel_o(n_s_sel),
    .s_stb_o(n_s_stb), .s_cyc_o(n_s_cyc),
    .s_dat_i(sdat), .s_ack_i(sack), .s_err_i(serr), .s_rty_i(srty),
    .gnt_o(n_gnt)
  );

  int total = 0;
  int bad = 0;

  // Reference model: who owns the bus, who owned it last, how long it has stalled.
  int owner = -1;
  int last  = NM - 1;
  int cnt   = 0;
  bit e_stalled, e_fire;

  typedef struct {
    bit       rst;
    logic [2:0] cyc;
    logic [2:0] stb;
    bit       ack;
    logic [2:0] gnt;
    bit       scyc;
    bit       sstb;
    logic [2:0] mack;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    last  = NM - 1;
    cnt   = 0;
  endtask

  task automatic model_check();
    bit busy, cg, sg, resp, scyc_e, sstb_e;
    logic [NM-1:0] oh;
    logic [AW-1:0] a_e;
    logic [DW-1:0] d_e;
    logic          w_e;
    logic [3:0]    s_e;
    busy = (owner >= 0);
    cg = 0; sg = 0; oh = '0; a_e = '0; d_e = '0; w_e = 0; s_e = '0;
    if (busy) begin
      cg  = cyc[owner];
      sg  = cg && stb[owner];
      oh  = NM'(1) << owner;
      a_e = adr[owner*AW +: AW];
      d_e = wdat[owner*DW +: DW];
      w_e = we[owner];
      s_e = sel[owner*4 +: 4];
    end
    resp      = sack | serr | srty;
    e_stalled = sg && !resp;
    e_fire    = e_stalled && (cnt == TO - 1);
    scyc_e    = cg && !e_fire;
    sstb_e    = sg && !e_fire;
    chk("gnt", gnt, oh);
    chk("s_cyc", s_cyc, scyc_e);
    chk("s_stb", s_stb, sstb_e);
    chk("s_adr", s_adr, a_e);
    chk("s_dat", s_dat, d_e);
    chk("s_we", s_we, w_e);
    chk("s_sel", s_sel, s_e);
    chk("m_ack", m_ack, (sack && scyc_e) ? oh : '0);
    chk("m_rty", m_rty, (srty && scyc_e) ? oh : '0);
    chk("m_err", m_err, ((serr && scyc_e) || e_fire) ? oh : '0);
    chk("m_dat", m_dat, sdat);
  endtask

  task automatic model_step();
    if (owner < 0) begin
      for (int i = 1; i <= NM; i++) begin
        if (owner < 0 && cyc[(last + i) % NM]) begin
          owner = (last + i) % NM;
          last  = owner;
        end
      end
      cnt = 0;
    end else if (!cyc[owner]) begin
      owner = -1;
      cnt   = 0;
    end else if (e_stalled && !e_fire) begin
      cnt++;
    end else begin
      cnt = 0;
    end
  endtask

  // Called with inputs settled (>=1 time unit after negedge); returns at next negedge.
  task automatic tick_rest();
    model_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic tick();
    #1;
    tick_rest();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc = '0; stb = '0; sack = 0; serr = 0; srty = 0; sdat = '0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_m_ack", m_ack, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_m_rty", m_rty, 0);
    chk("rst_s_adr", s_adr, 0);
    chk("rst_s_dat", s_dat, 0);
    chk("rst_s_we", s_we, 0);
    chk("rst_s_sel", s_sel, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int order[$];
    bit done[NM];
    logic [NM-1:0] prev_gnt;
    int errs;

    //            rst   cyc     stb     ack   gnt     scyc  sstb  mack
    vecs[0]  = '{1'b1, 3'b001, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};
    vecs[1]  = '{1'b0, 3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001};
    vecs[2]  = '{1'b0, 3'b000, 3'b000, 1'b1, 3'b001, 1'b0, 1'b0, 3'b000};
    vecs[3]  = '{1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};
    vecs[4]  = '{1'b1, 3'b011, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};
    vecs[5]  = '{1'b0, 3'b011, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000};
    vecs[6]  = '{1'b0, 3'b011, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000};
    vecs[7]  = '{1'b0, 3'b011, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000};
    vecs[8]  = '{1'b0, 3'b010, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000};
    vecs[9]  = '{1'b0, 3'b010, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};
    vecs[10] = '{1'b0, 3'b010, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0, 3'b000};
    vecs[11] = '{1'b0, 3'b000, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 3'b000};
    vecs[12] = '{1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};

    for (int k = 0; k < NM; k++) begin
      adr[k*AW +: AW]  = 32'h1000_0000 + 32'(k) * 32'h100;
      wdat[k*DW +: DW] = 32'hD000_0000 + 32'(k);
      sel[k*4 +: 4]    = 4'hF;
    end
    we = 3'b010;
    cyc = '0; stb = '0; sack = 0; serr = 0; srty = 0; sdat = '0;
    @(negedge clk);

    // Single read, ack-with-release boundary, post-reset tie and dead cycle.
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      cyc  = vecs[i].cyc;
      stb  = vecs[i].stb;
      sack = vecs[i].ack;
      sdat = 32'hCAFE0001;
      #1;
      chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
      chk($sformatf("vec%0d_s_cyc", i), s_cyc, vecs[i].scyc);
      chk($sformatf("vec%0d_s_stb", i), s_stb, vecs[i].sstb);
      chk($sformatf("vec%0d_m_ack", i), m_ack, vecs[i].mack);
      chk($sformatf("vec%0d_m_dat", i), m_dat, 32'hCAFE0001);
      if (vecs[i].gnt == 3'b001) chk($sformatf("vec%0d_s_adr", i), s_adr, 32'h1000_0000);
      if (vecs[i].gnt == 3'b010) chk($sformatf("vec%0d_s_adr", i), s_adr, 32'h1000_0100);
      tick_rest();
    end

    // Fairness: two masters, one acked beat per tenure, re-requesting at once.
    do_reset();
    prev_gnt = '0;
    done = '{default: 0};
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      int o;
      bit beat;
      o = owner;
      beat = (o >= 0) && !done[o];
      for (int m = 0; m < 2; m++) begin
        if (o == m) begin
          cyc[m] = !done[m];
          stb[m] = !done[m];
        end else begin
          cyc[m] = 1'b1;
          stb[m] = 1'b0;
        end
      end
      sack = beat;
      #1;
      if (gnt != 0 && prev_gnt == 0) order.push_back(gnt == 3'b001 ? 0 : (gnt == 3'b010 ? 1 : 2));
      prev_gnt = gnt;
      tick_rest();
      if (beat) done[o] = 1;
      if (owner < 0) done = '{default: 0};
    end
    chk("fair_grants", order.size(), 6);
    foreach (order[i]) chk($sformatf("fair_order%0d", i), order[i], i % 2);

    // Locked burst: m0 does 4 acked beats while m1 strobes; m1 waits.
    do_reset();
    cyc = 3'b001; stb = 3'b000;
    #1; chk("burst_c0_gnt", gnt, 3'b000); tick_rest();
    for (int b = 0; b < 4; b++) begin
      cyc = 3'b011; stb = 3'b011; sack = 1;
      #1;
      chk($sformatf("burst_b%0d_gnt", b), gnt, 3'b001);
      chk($sformatf("burst_b%0d_ack", b), m_ack, 3'b001);
      tick_rest();
    end
    cyc = 3'b010; stb = 3'b010; sack = 0;
    #1; chk("burst_rel_gnt", gnt, 3'b001); tick_rest();
    #1; chk("burst_dead_gnt", gnt, 3'b000); tick_rest();
    #1; chk("burst_m1_gnt", gnt, 3'b010); chk("burst_m1_stb", s_stb, 1); tick_rest();

    // Watchdog: silent slave; fires on the 8th stalled cycle; TIMEOUT=0 never fires.
    do_reset();
    cyc = 3'b001; stb = 3'b001;
    tick();
    errs = 0;
    for (int i = 1; i <= 9; i++) begin
      #1;
      chk($sformatf("wd_c%0d_err", i), m_err, (i == 8) ? 3'b001 : 3'b000);
      chk($sformatf("wd_c%0d_s_cyc", i), s_cyc, (i == 8) ? 1'b0 : 1'b1);
      chk($sformatf("wd_c%0d_s_stb", i), s_stb, (i == 8) ? 1'b0 : 1'b1);
      if (n_m_err != 0) errs++;
      tick_rest();
    end
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (n_m_err != 0 || !n_s_cyc) errs++;
      tick_rest();
    end
    chk("nowd_err_count", errs, 0);
    chk("nowd_gnt", n_gnt, 3'b001);

    // Async reset mid-burst with m1 owning the bus.
    do_reset();
    cyc = 3'b010; stb = 3'b010;
    tick();
    cyc = 3'b011; stb = 3'b011;
    tick();
    #3;
    reset = 1'b1;
    #1;
    chk("areset_gnt", gnt, 3'b000);
    chk("areset_s_cyc", s_cyc, 0);
    chk("areset_s_stb", s_stb, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    tick();
    #1; chk("areset_first_gnt", gnt, 3'b001); tick_rest();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NM; k++) begin
        if ($urandom_range(0, 4) == 0) cyc[k] = ~cyc[k];
        stb[k] = ($urandom_range(0, 3) != 0);
        we[k]  = $urandom_range(0, 1) == 1;
        sel[k*4 +: 4]    = 4'($urandom);
        adr[k*AW +: AW]  = $urandom;
        wdat[k*DW +: DW] = $urandom;
      end
      sdat = $urandom;
      sack = ($urandom_range(0, 3) == 0);
      serr = ($urandom_range(0, 15) == 0);
      srty = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
